dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data memory with a request/acknowledge handshake, programmable access latency, byte-addressed word-aligned accesses, and error reporting for misaligned or out-of-range addresses. It replaces the fixed 8-word, always-ready data memory in the MEM stage. The pipeline's hazard unit stalls on `Ready_o`/`Ack_o`, so a slower memory drops in without pipeline changes.

## Interface
- `DATA_W`, 32: word width in bits; power of two, at least 8.
- `DEPTH`, 32: number of words; power of two.
- `LATENCY`, 1: cycles from accept to acknowledge; legal range 1..15.
- `clk_i`  in  1: clock; all state changes on its rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `Req_i`  in  1: request valid.
- `Write_i`  in  1: 1 = write, 0 = read; sampled with `Req_i`.
- `Address_i`  in  32: byte address.
- `WriteData_i`  in  DATA_W: write data.
- `ByteEn_i`  in  DATA_W/8: byte write mask; bit k covers bits [8k+7:8k].
- `Ready_o`  out  1: block can accept a request this cycle.
- `Ack_o`  out  1: one-cycle completion pulse.
- `Error_o`  out  1: valid with `Ack_o`; the access was rejected.
- `ReadData_o`  out  DATA_W: read result; valid when `Ack_o`=1, `Error_o`=0, and the request was a read.

## Operation
- `OFFS` = log2(DATA_W/8). The word index is `Address_i >> OFFS`.
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE:**
  - `Ready_o`=1.
  - The block accepts on the edge where `Req_i`=1.
  - It latches op, address, data and mask.
  - It loads the counter with `LATENCY`-1.
  - Next state is RESP if `LATENCY`=1, else BUSY.
  - If `Req_i`=0, it stays in IDLE.
- **BUSY:**
  - `Ready_o`=0.
  - The counter decrements each edge.
  - On the edge where the counter is 1, the FSM goes to RESP.
- **Memory access:** the access happens on the edge that enters RESP and uses the latched request.
  - Write: each enabled byte of word[index] is updated.
  - Read: `ReadData_o` is loaded with word[index] as it was before that edge.
- **RESP:**
  - `Ack_o`=1 and `Ready_o`=0.
  - Next edge goes to IDLE unconditionally.
- **Error condition:** low `OFFS` address bits are nonzero, or index ≥ `DEPTH`.
  - No memory change occurs.
  - `ReadData_o` holds its previous value.
  - `Error_o`=1 during RESP.
- Write with an all-zero `ByteEn_i`: legal no-op that is still acknowledged.
- `ReadData_o` holds its value between read acknowledges. Writes and errors do not change it.
- Requests are not queued. `Req_i` outside IDLE is ignored; the master must hold `Req_i` until `Ready_o`=1.

## Timing
- **Reset** (while `rst_i`=1 at an edge): next state is IDLE, counter is 0, `Ack_o`=0, `Error_o`=0, `ReadData_o`=0.
  - `Ready_o` is forced to 0 while `rst_i`=1.
  - Memory contents are not reset.
- **Reset mid-operation:** reset has priority over the pending access. The in-flight request is dropped, with no write and no `Ack_o`.
- **Latency:** accept at edge e0, then `Ack_o` is high in the cycle after edge e0+`LATENCY`-1.
  - `LATENCY`=1 gives `Ack_o` the cycle after accept.
- **Throughput:** one request per `LATENCY`+1 cycles.
- **Back-to-back:** `Ready_o` is high the cycle after `Ack_o`.
- Outputs `Ack_o`, `Error_o` and `ReadData_o` are registered. `Ready_o` decodes from the state register and `rst_i` only.

## Configuration
- **`DMEM_BYTE_WRITE_EN` defined:** writes honour `ByteEn_i` per byte.
- **Not defined:** `ByteEn_i` is ignored and every write updates the full word.
  - Misalignment is still checked.
  - Handshake and timing are identical in both builds.

## Structure
- **Package `dmem_pkg`:**
  - state enum `dmem_state_t` (IDLE, BUSY, RESP);
  - counter width constant `DMEM_CNT_W` = 4;
  - function `dmem_offs(DATA_W)` returning `OFFS`.
- **Sub-module `dmem_array`:** a synchronous single-port array with word write and per-byte write mask, registered read port and no reset.
  - The controller FSM, latency counter and error check stay in `dmem_ctrl`.

## Test plan
- **Reset:** assert `rst_i` 2 cycles.
  - During reset: `Ready_o`=0, `Ack_o`=0, `ReadData_o`=0.
  - First cycle after release: `Ready_o`=1.
- **Write/read, LATENCY=1, DATA_W=32:** write 0xDEADBEEF to address 0x10 with `ByteEn_i`=0xF, then read 0x10.
  - Each `Ack_o` arrives one cycle after accept.
  - Read returns 0xDEADBEEF with `Error_o`=0.
- **Byte mask (`DMEM_BYTE_WRITE_EN` on):** write 0x000000AA, `ByteEn_i`=0x1, onto 0xDEADBEEF.
  - Read returns 0xDEADBEAA.
  - With the macro off, the read returns 0x000000AA.
- **Errors:**
  - Read 0x12 gives `Ack_o`+`Error_o`, with `ReadData_o` unchanged.
  - Write to byte address `DEPTH`*4 gives `Error_o` and no array change.
- **LATENCY=4 with back-to-back requests:**
  - `Ack_o` arrives exactly 4 cycles after each accept.
  - `Req_i` held during BUSY/RESP is accepted only when `Ready_o`=1.
  - Requests are spaced 5 cycles apart.
- **Reset mid-write, LATENCY=4:** assert `rst_i` 2 cycles after accept.
  - No `Ack_o` is produced.
  - A subsequent read of that address returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_t;

  localparam int DMEM_CNT_W = 4;

  function automatic int dmem_offs(input int dataW);
    return $clog2(dataW / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word array: per-byte write mask, registered read port, no reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic                wrEn,
  input  logic                rdEn,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wrData,
  input  logic [DATA_W/8-1:0] byteEn,
  output logic [DATA_W-1:0]   rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read sees the word as it was before a same-edge write.
  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (byteEn[b]) mem[addr][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
    if (rdEn) rdData <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: req/ack handshake, programmable latency, alignment/range errors.
// Build option: define DMEM_BYTE_WRITE_EN to honour ByteEn_i; otherwise writes update the full word.
//
// state | meaning
// IDLE  | ready, accepts a request on Req_i
// BUSY  | latency counter running down
// RESP  | Ack_o (and Error_o) presented for one cycle
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                Req_i,
  input  logic                Write_i,
  input  logic [31:0]         Address_i,
  input  logic [DATA_W-1:0]   WriteData_i,
  input  logic [DATA_W/8-1:0] ByteEn_i,
  output logic                Ready_o,
  output logic                Ack_o,
  output logic                Error_o,
  output logic [DATA_W-1:0]   ReadData_o
);

  localparam int OFFS = dmem_offs(DATA_W);
  localparam int BE_W = DATA_W / 8;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ALIGN_MASK = (32'd1 << OFFS) - 32'd1;
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);
`ifdef DMEM_BYTE_WRITE_EN
  localparam bit BYTE_WRITE_EN = 1'b1;
`else
  localparam bit BYTE_WRITE_EN = 1'b0;
`endif

  dmem_state_t state, nextState;
  logic [DMEM_CNT_W-1:0] cnt, cntNext;
  logic access, doAccess, accept;

  logic              opWrite;
  logic [31:0]       addrQ;
  logic [DATA_W-1:0] dataQ;
  logic [BE_W-1:0]   maskQ;

  logic              selWrite;
  logic [31:0]       selAddr;
  logic [DATA_W-1:0] selData;
  logic [BE_W-1:0]   selMask;
  logic [BE_W-1:0]   wrMask;
  logic              selErr;

  logic              ackQ, errQ, rdValid;
  logic [DATA_W-1:0] arrRd;

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (Req_i) begin
          cntNext = CNT_LOAD;
          if (LATENCY == 1) begin
            nextState = RESP;
            access    = 1'b1;
          end else begin
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
        cntNext = cnt - DMEM_CNT_W'(1);
        if (cnt == DMEM_CNT_W'(1)) begin
          nextState = RESP;
          access    = 1'b1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && Req_i;

  // With single-cycle latency the access edge is also the accept edge, so the live inputs are used.
  assign selWrite = (state == IDLE) ? Write_i     : opWrite;
  assign selAddr  = (state == IDLE) ? Address_i   : addrQ;
  assign selData  = (state == IDLE) ? WriteData_i : dataQ;
  assign selMask  = (state == IDLE) ? ByteEn_i    : maskQ;
  assign wrMask   = selMask | {BE_W{!BYTE_WRITE_EN}};

  assign selErr   = (|(selAddr & ALIGN_MASK)) || ((selAddr >> OFFS) >= 32'(DEPTH));
  assign doAccess = access && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ackQ    <= 1'b0;
      errQ    <= 1'b0;
      rdValid <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      ackQ  <= access;
      errQ  <= access && selErr;
      if (access && !selWrite && !selErr) rdValid <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      opWrite <= Write_i;
      addrQ   <= Address_i;
      dataQ   <= WriteData_i;
      maskQ   <= ByteEn_i;
    end
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uArray (
    .clk_i (clk_i),
    .wrEn  (doAccess && selWrite && !selErr),
    .rdEn  (doAccess && !selWrite && !selErr),
    .addr  (selAddr[OFFS +: AW]),
    .wrData(selData),
    .byteEn(wrMask),
    .rdData(arrRd)
  );

  // The array register has no reset; rdValid supplies the zero after reset.
  assign ReadData_o = rdValid ? arrRd : '0;
  assign Ack_o      = ackQ;
  assign Error_o    = errQ;
  assign Ready_o    = !rst_i && (state == IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one LATENCY=1 and one LATENCY=4 instance share stimulus.
module tb_dmem_ctrl;

  localparam int DEPTH = 32;
`ifdef DMEM_BYTE_WRITE_EN
  localparam bit BWE = 1'b1;
`else
  localparam bit BWE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req1 = 1'b0, req4 = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        rdy1, ack1, err1, rdy4, ack4, err4;
  logic [31:0] rd1, rd4;

  dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(1)) dutL1 (
    .clk_i(clk), .rst_i(rst), .Req_i(req1), .Write_i(wr), .Address_i(addr),
    .WriteData_i(wdata), .ByteEn_i(be), .Ready_o(rdy1), .Ack_o(ack1),
    .Error_o(err1), .ReadData_o(rd1));

  dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(4)) dutL4 (
    .clk_i(clk), .rst_i(rst), .Req_i(req4), .Write_i(wr), .Address_i(addr),
    .WriteData_i(wdata), .ByteEn_i(be), .Ready_o(rdy4), .Ack_o(ack4),
    .Error_o(err4), .ReadData_o(rd4));

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          accEdge;
  } exp_t;

  exp_t        sb1[$], sb4[$];
  logic [31:0] model1[DEPTH], model4[DEPTH];
  logic [31:0] lastRd1 = '0, lastRd4 = '0;
  int          cyc = 0;
  int          nVec = 0, nFail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one request, wait for acceptance, and push the model's expected completion.
  task automatic issue(input int lat, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit hold);
    exp_t        e;
    int          idx, budget;
    logic [31:0] nw;
    @(negedge clk);
    wr = w; addr = a; wdata = d; be = b;
    if (lat == 1) req1 = 1'b1; else req4 = 1'b1;
    budget = 0;
    while (((lat == 1) ? rdy1 : rdy4) !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 40) begin
      nVec++; nFail++;
      $display("FAIL ready_timeout lat=%0d: Ready_o stayed low, wanted 1", lat);
    end
    @(posedge clk);
    #1;
    if (!hold) begin req1 = 1'b0; req4 = 1'b0; end
    e.accEdge = cyc;
    e.err     = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    idx       = int'(a >> 2);
    if (!e.err && w) begin
      nw = (lat == 1) ? model1[idx] : model4[idx];
      for (int k = 0; k < 4; k++) if (b[k] || !BWE) nw[8*k +: 8] = d[8*k +: 8];
      if (lat == 1) model1[idx] = nw; else model4[idx] = nw;
    end else if (!e.err && !w) begin
      if (lat == 1) lastRd1 = model1[idx]; else lastRd4 = model4[idx];
    end
    e.data = (lat == 1) ? lastRd1 : lastRd4;
    if (lat == 1) sb1.push_back(e); else sb4.push_back(e);
  endtask

  // Observation only: returns what the DUT presented on its next Ack_o.
  task automatic waitAck(input int lat, output bit seen, output int ed, output bit e,
                         output logic [31:0] rd);
    seen = 1'b0; ed = 0; e = 1'b0; rd = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (((lat == 1) ? ack1 : ack4) === 1'b1) begin
        seen = 1'b1;
        ed   = cyc;
        e    = (lat == 1) ? err1 : err4;
        rd   = (lat == 1) ? rd1 : rd4;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req1 = 1'b0; req4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nVec += 6;
      if (rdy1 !== 1'b0) begin nFail++; $display("FAIL rst_ready1 got %b want 0", rdy1); end
      if (ack1 !== 1'b0) begin nFail++; $display("FAIL rst_ack1 got %b want 0", ack1); end
      if (rd1 !== 32'h0) begin nFail++; $display("FAIL rst_rdata1 got %h want 0", rd1); end
      if (rdy4 !== 1'b0) begin nFail++; $display("FAIL rst_ready4 got %b want 0", rdy4); end
      if (ack4 !== 1'b0) begin nFail++; $display("FAIL rst_ack4 got %b want 0", ack4); end
      if (rd4 !== 32'h0) begin nFail++; $display("FAIL rst_rdata4 got %h want 0", rd4); end
    end
    rst = 1'b0;
    lastRd1 = '0; lastRd4 = '0;
    @(negedge clk);
    nVec += 2;
    if (rdy1 !== 1'b1) begin nFail++; $display("FAIL rel_ready1 got %b want 1", rdy1); end
    if (rdy4 !== 1'b1) begin nFail++; $display("FAIL rel_ready4 got %b want 1", rdy4); end
  endtask

  task automatic test_wr_rd();
    bit seen, e; int ed; logic [31:0] rd; exp_t x;
    for (int t = 0; t < 2; t++) begin
      issue(1, (t == 0), 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      waitAck(1, seen, ed, e, rd);
      x = sb1.pop_front();
      nVec++;
      if (!seen) begin nFail++; $display("FAIL wr_rd[%0d] ack got 0 want 1", t); end
      else begin
        nVec += 3;
        if (e !== x.err) begin nFail++; $display("FAIL wr_rd[%0d] err got %b want %b", t, e, x.err); end
        if (rd !== x.data) begin nFail++; $display("FAIL wr_rd[%0d] rdata got %h want %h", t, rd, x.data); end
        if (ed - x.accEdge != 0) begin nFail++; $display("FAIL wr_rd[%0d] latency got %0d want 0", t, ed - x.accEdge); end
      end
    end
    @(negedge clk);
    nVec += 2;
    if (ack1 !== 1'b0) begin nFail++; $display("FAIL ack_pulse got %b want 0", ack1); end
    if (rdy1 !== 1'b1) begin nFail++; $display("FAIL ready_after_ack got %b want 1", rdy1); end
  endtask

  task automatic test_byte_mask();
    bit seen, e; int ed; logic [31:0] rd; exp_t x;
    for (int t = 0; t < 2; t++) begin
      issue(1, (t == 0), 32'h10, 32'h000000AA, 4'h1, 1'b0);
      waitAck(1, seen, ed, e, rd);
      x = sb1.pop_front();
      nVec++;
      if (!seen) begin nFail++; $display("FAIL mask[%0d] ack got 0 want 1", t); end
      else begin
        nVec += 2;
        if (e !== x.err) begin nFail++; $display("FAIL mask[%0d] err got %b want %b", t, e, x.err); end
        if (rd !== x.data) begin nFail++; $display("FAIL mask[%0d] rdata got %h want %h", t, rd, x.data); end
      end
    end
  endtask

  task automatic test_errors();
    bit seen, e; int ed; logic [31:0] rd; exp_t x;
    bit          wv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] av[5] = '{32'h0, 32'h0, 32'h12, 32'h80, 32'h0};
    logic [31:0] dv[5] = '{32'h11223344, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    for (int t = 0; t < 5; t++) begin
      issue(1, wv[t], av[t], dv[t], 4'hF, 1'b0);
      waitAck(1, seen, ed, e, rd);
      x = sb1.pop_front();
      nVec++;
      if (!seen) begin nFail++; $display("FAIL err[%0d] ack got 0 want 1", t); end
      else begin
        nVec += 2;
        if (e !== x.err) begin nFail++; $display("FAIL err[%0d] error got %b want %b", t, e, x.err); end
        if (rd !== x.data) begin nFail++; $display("FAIL err[%0d] rdata got %h want %h", t, rd, x.data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen, e; int ed, prevAcc; logic [31:0] rd; exp_t x;
    issue(4, 1'b1, 32'h24, 32'h0BADCAFE, 4'hF, 1'b0);
    waitAck(4, seen, ed, e, rd);
    x = sb4.pop_front();
    nVec++;
    if (!seen || ed - x.accEdge != 3) begin
      nFail++; $display("FAIL b2b_pre ack seen=%b latency=%0d want 1/3", seen, ed - x.accEdge);
    end
    prevAcc = 0;
    fork
      begin
        issue(4, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1);
        issue(4, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1);
        issue(4, 1'b1, 32'h24, 32'h00000055, 4'h0, 1'b1);
        issue(4, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0);
      end
      begin
        for (int t = 0; t < 4; t++) begin
          waitAck(4, seen, ed, e, rd);
          x = sb4.pop_front();
          nVec++;
          if (!seen) begin nFail++; $display("FAIL b2b[%0d] ack got 0 want 1", t); end
          else begin
            nVec += 3;
            if (e !== x.err) begin nFail++; $display("FAIL b2b[%0d] err got %b want %b", t, e, x.err); end
            if (rd !== x.data) begin nFail++; $display("FAIL b2b[%0d] rdata got %h want %h", t, rd, x.data); end
            if (ed - x.accEdge != 3) begin nFail++; $display("FAIL b2b[%0d] latency got %0d want 3", t, ed - x.accEdge); end
            if (t > 0) begin
              nVec++;
              if (x.accEdge - prevAcc != 5) begin nFail++; $display("FAIL b2b[%0d] spacing got %0d want 5", t, x.accEdge - prevAcc); end
            end
          end
          prevAcc = x.accEdge;
        end
      end
    join
  endtask

  task automatic test_reset_mid_write();
    bit seen, e, sawAck; int ed, budget; logic [31:0] rd; exp_t x;
    issue(4, 1'b1, 32'h30, 32'h600DF00D, 4'hF, 1'b0);
    waitAck(4, seen, ed, e, rd);
    x = sb4.pop_front();
    nVec++;
    if (!seen) begin nFail++; $display("FAIL midrst_pre ack got 0 want 1"); end
    @(negedge clk);
    wr = 1'b1; addr = 32'h30; wdata = 32'hBAD0BAD0; be = 4'hF; req4 = 1'b1;
    budget = 0;
    while (rdy4 !== 1'b1 && budget < 40) begin @(negedge clk); budget++; end
    @(posedge clk);
    #1 req4 = 1'b0;
    sawAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack4 === 1'b1) sawAck = 1'b1;
      if (i == 1) rst = 1'b1;
      if (i == 3) rst = 1'b0;
    end
    lastRd1 = '0; lastRd4 = '0;
    nVec++;
    if (sawAck !== 1'b0) begin nFail++; $display("FAIL midrst_ack got %b want 0", sawAck); end
    issue(4, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
    waitAck(4, seen, ed, e, rd);
    x = sb4.pop_front();
    nVec++;
    if (!seen) begin nFail++; $display("FAIL midrst_read ack got 0 want 1"); end
    else begin
      nVec++;
      if (rd !== x.data) begin nFail++; $display("FAIL midrst_read rdata got %h want %h", rd, x.data); end
    end
  endtask

  initial begin
    test_reset();
    test_wr_rd();
    test_byte_mask();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
